// File: rtl/word_block_counter.sv
// word_block_counter: Skein word/block position tracker with wrap or saturate overflow
//   clk_i           rising-edge clock
//   rst_n_i         asynchronous active-low reset
//   clear_i         synchronous clear of all state, overrides any step
//   plus_1_i        advance word index by 1 (wins over plus_2_i)
//   plus_2_i        advance word index by 2
//   word_counter_o  word index within the current block
//   block_counter_o completed blocks (WRAP_MODE=1 only)
//   byte_pos_o      bytes consumed since clear
//   last_word_o     word index is BLOCK_WORDS-1
//   block_done_o    one-cycle pulse when the index wraps
//   overflow_o      sticky saturation flag (WRAP_MODE=0 only)
module word_block_counter #(
  parameter int CNT_W       = 4,
  parameter int BLOCK_WORDS = 16,
  parameter int WORD_BYTES  = 8,
  parameter int POS_W       = 96,
  parameter int BLK_W       = 32,
  parameter int WRAP_MODE   = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             plus_1_i,
  input  logic             plus_2_i,
  output logic [CNT_W-1:0] word_counter_o,
  output logic [BLK_W-1:0] block_counter_o,
  output logic [POS_W-1:0] byte_pos_o,
  output logic             last_word_o,
  output logic             block_done_o,
  output logic             overflow_o
);
  localparam logic WRAP = (WRAP_MODE != 0);
  localparam logic [CNT_W:0] BW = (CNT_W+1)'(BLOCK_WORDS);
  localparam logic [CNT_W:0] LAST = (CNT_W+1)'(BLOCK_WORDS - 1);
  logic [1:0]       step;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   used;
  logic             hit;
  logic [CNT_W-1:0] word_d;
  // sum is one bit wider than the index so it cannot alias at 2^CNT_W
  always_comb begin
    step   = plus_1_i ? 2'd1 : plus_2_i ? 2'd2 : 2'd0;
    sum    = {1'b0, word_counter_o} + (CNT_W+1)'(step);
    hit    = sum >= BW;
    word_d = !hit ? CNT_W'(sum) : WRAP ? CNT_W'(sum - BW) : CNT_W'(LAST);
    // when saturating, only the words up to the last slot are consumed
    used   = (hit && !WRAP) ? LAST - {1'b0, word_counter_o} : (CNT_W+1)'(step);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_counter_o  <= '0;
      block_counter_o <= '0;
      byte_pos_o      <= '0;
      block_done_o    <= 1'b0;
      overflow_o      <= 1'b0;
    end else if (clear_i) begin
      word_counter_o  <= '0;
      block_counter_o <= '0;
      byte_pos_o      <= '0;
      block_done_o    <= 1'b0;
      overflow_o      <= 1'b0;
    end else begin
      word_counter_o  <= word_d;
      block_counter_o <= block_counter_o + BLK_W'(WRAP && hit);
      byte_pos_o      <= byte_pos_o + POS_W'(used) * POS_W'(WORD_BYTES);
      block_done_o    <= WRAP && hit;
      overflow_o      <= overflow_o || (!WRAP && hit);
    end
  end
  assign last_word_o = word_counter_o == CNT_W'(BLOCK_WORDS - 1);
endmodule
